// File: rtl/button_bounce_gen.sv
// button_bounce_gen: mechanical-button emulator producing contact bounce on each commanded level change.
//
// Ports:
//   i_w_clk         in   clock
//   i_w_reset_n     in   asynchronous active-low reset
//   i_w_level       in   clean commanded button level
//   o_r_button_out  out  bouncing raw button signal (registered)
//   o_r_settled     out  last fully settled level
//   o_r_busy        out  high while an event is in progress
//   o_r_bounce_cnt  out  [7:0] transitions of o_r_button_out in the current/last event, saturating
//
// Build option: BOUNCE_GEN_FIXED_EN -- when defined, toggles are spaced exactly MIN_HOLD
// clocks apart instead of using the LFSR to jitter the spacing.
module button_bounce_gen #(
    parameter int          BOUNCE_CYCLES = 16,
    parameter int          MIN_HOLD      = 4,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic       i_w_clk,
    input  logic       i_w_reset_n,
    input  logic       i_w_level,
    output logic       o_r_button_out,
    output logic       o_r_settled,
    output logic       o_r_busy,
    output logic [7:0] o_r_bounce_cnt
);
    typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

    // An all-zero Fibonacci LFSR would lock up, so substitute a legal seed.
    localparam logic [15:0] SEED     = (LFSR_SEED == 16'd0) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] WIN_INIT = 16'(BOUNCE_CYCLES - 1);

    state_t      state, state_nxt;
    logic [15:0] lfsr, win, win_nxt, dwell, dwell_nxt, reload;
    logic        target, target_nxt, out_nxt, settled_nxt, busy_nxt;
    logic [7:0]  cnt_nxt, cnt_inc;

`ifdef BOUNCE_GEN_FIXED_EN
    assign reload = 16'(MIN_HOLD - 1);
`else
    assign reload = 16'(MIN_HOLD - 1) + {12'd0, lfsr[3:0]};
`endif

    assign cnt_inc = (o_r_bounce_cnt == 8'hFF) ? 8'hFF : o_r_bounce_cnt + 8'd1;

    always_comb begin
        state_nxt   = state;
        target_nxt  = target;
        win_nxt     = win;
        dwell_nxt   = dwell;
        out_nxt     = o_r_button_out;
        settled_nxt = o_r_settled;
        busy_nxt    = o_r_busy;
        cnt_nxt     = o_r_bounce_cnt;
        case (state)
            IDLE: begin
                out_nxt = o_r_settled;
                if (i_w_level != o_r_settled) begin
                    target_nxt = i_w_level;
                    out_nxt    = i_w_level;
                    cnt_nxt    = 8'd1;
                    busy_nxt   = 1'b1;
                    win_nxt    = WIN_INIT;
                    dwell_nxt  = reload;
                    state_nxt  = BOUNCE;
                end
            end
            BOUNCE: begin
                if (win == 16'd0) begin
                    // Window closed: force the final level, counting it only if it is a real edge.
                    out_nxt   = target;
                    cnt_nxt   = (o_r_button_out != target) ? cnt_inc : o_r_bounce_cnt;
                    state_nxt = SETTLE;
                end else begin
                    win_nxt   = win - 16'd1;
                    out_nxt   = (dwell == 16'd0) ? ~o_r_button_out : o_r_button_out;
                    cnt_nxt   = (dwell == 16'd0) ? cnt_inc : o_r_bounce_cnt;
                    dwell_nxt = (dwell == 16'd0) ? reload : dwell - 16'd1;
                end
            end
            SETTLE: begin
                settled_nxt = target;
                busy_nxt    = 1'b0;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_w_clk or negedge i_w_reset_n) begin
        if (!i_w_reset_n) begin
            state          <= IDLE;
            lfsr           <= SEED;
            target         <= 1'b0;
            win            <= 16'd0;
            dwell          <= 16'd0;
            o_r_button_out <= 1'b0;
            o_r_settled    <= 1'b0;
            o_r_busy       <= 1'b0;
            o_r_bounce_cnt <= 8'd0;
        end else begin
            state          <= state_nxt;
            lfsr           <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            target         <= target_nxt;
            win            <= win_nxt;
            dwell          <= dwell_nxt;
            o_r_button_out <= out_nxt;
            o_r_settled    <= settled_nxt;
            o_r_busy       <= busy_nxt;
            o_r_bounce_cnt <= cnt_nxt;
        end
    end
endmodule
